// File: rtl/esquema_chave.sv
// SIMON 128/128 round-key generator: expands a 128-bit master key into 68
// 64-bit round keys, one per clock, starting from k0 on the first cycle after reset.
module esquema_chave #(
   parameter int ROUNDS = 68,
   parameter int WORD   = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2*WORD-1:0] k0_i,
   output logic [WORD-1:0]   kj_o,
   output logic [1:0]        dbg_state
);

   localparam logic [WORD-1:0] C        = 64'hFFFF_FFFF_FFFF_FFFC;
   // z2 stored with an ascending range so that Z2[j] is z[j] (z[0] is the leftmost bit).
   localparam logic [0:61]     Z2       = 62'b10101111011100000011010010011000101000010001111110010110110011;
   localparam logic [6:0]      IDX_LAST = 7'(ROUNDS - 1);

   // Encoding is visible on dbg_state: 0 = waiting to load, 1 = expanding, 2 = holding k[ROUNDS-1].
   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t          state;
   logic [6:0]      idx;
   logic [5:0]      zi;
   logic [WORD-1:0] x;
   logic [WORD-1:0] y;
   logic [WORD-1:0] y_next;
   logic [WORD-1:0] y_load;
   logic            r;

   function automatic logic [WORD-1:0] key_f(input logic [WORD-1:0] u,
                                             input logic [WORD-1:0] v,
                                             input logic            zb);
      return C ^ u ^ {v[2:0], v[WORD-1:3]} ^ {v[3:0], v[WORD-1:4]} ^ {{(WORD-1){1'b0}}, zb};
   endfunction

   always_comb begin
      y_next = key_f(x, y, Z2[zi]);
      y_load = key_f(k0_i[WORD-1:0], k0_i[2*WORD-1:WORD], Z2[0]);
   end

   // zi tracks idx mod 62 so the z2 sequence restarts at z[0] for k64.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_LOAD;
         idx   <= 7'd0;
         zi    <= 6'd0;
         x     <= '0;
         y     <= '0;
      end else begin
         case (state)
            ST_LOAD: begin
               x     <= k0_i[2*WORD-1:WORD];
               y     <= y_load;
               idx   <= 7'd1;
               zi    <= 6'd1;
               state <= (IDX_LAST == 7'd1) ? ST_HOLD : ST_RUN;
            end
            ST_RUN: begin
               x     <= y;
               y     <= y_next;
               idx   <= idx + 7'd1;
               zi    <= (zi == 6'd61) ? 6'd0 : zi + 6'd1;
               if (idx == IDX_LAST - 7'd1) state <= ST_HOLD;
            end
            ST_HOLD: begin
               state <= ST_HOLD;
            end
            default: begin
               state <= ST_LOAD;
            end
         endcase
      end
   end

   // Until the first load, x is not yet valid, so k0 is passed straight through from the key input.
   assign r         = (state != ST_LOAD);
   assign kj_o      = r ? x : k0_i[WORD-1:0];
   assign dbg_state = state;

endmodule

// File: tb/tb_esquema_chave.sv
// Bench for esquema_chave: a software SIMON 128/128 key-expansion model fills an
// expected queue per sequence; kj_o is sampled on the falling edge and compared.
module tb_esquema_chave;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [127:0] k0_i = '0;
   logic [63:0]  kj_o;
   logic [1:0]   dbg_state;

   always #5 clk = ~clk;

   esquema_chave #(.ROUNDS(68), .WORD(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .k0_i      (k0_i),
      .kj_o      (kj_o),
      .dbg_state (dbg_state)
   );

   localparam logic [63:0]  C_TB  = 64'hFFFF_FFFF_FFFF_FFFC;
   // Descending range here: z[j] is bit 61-j.
   localparam logic [61:0]  Z2_TB = 62'b10101111011100000011010010011000101000010001111110010110110011;
   localparam logic [127:0] KEY_A = 128'h1b1a1918131211100b0a090803020100;

   logic [63:0] exp_q[$];
   logic [63:0] mk   [0:67];
   logic [63:0] seen [0:67];
   int          tests_run    = 0;
   int          tests_failed = 0;

   function automatic logic [63:0] ror(input logic [63:0] v, input int s);
      return (v >> s) | (v << (64 - s));
   endfunction

   function automatic logic [63:0] model_f(input logic [63:0] u, input logic [63:0] v, input int j);
      logic [63:0] zw;
      zw = 64'd0;
      zw[0] = Z2_TB[61 - j];
      return C_TB ^ zw ^ u ^ ror(v, 3) ^ ror(v, 4);
   endfunction

   task automatic build_model(input logic [127:0] key);
      mk[0] = key[63:0];
      mk[1] = key[127:64];
      for (int i = 2; i < 68; i++) mk[i] = model_f(mk[i-2], mk[i-1], (i - 2) % 62);
   endtask

   // Reset with a new key, load the scoreboard, and release rst between clock edges.
   task automatic start_seq(input logic [127:0] key);
      rst  = 1'b1;
      k0_i = key;
      exp_q.delete();
      build_model(key);
      for (int i = 0; i < 68; i++) exp_q.push_back(mk[i]);
      @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic next_sample(output logic [63:0] got, output logic [63:0] exp, output bit have);
      @(negedge clk);
      #1;
      got = kj_o;
      if (exp_q.size() == 0) begin
         have = 1'b0;
         exp  = '0;
      end else begin
         have = 1'b1;
         exp  = exp_q.pop_front();
      end
   endtask

   task automatic test_reset;
      logic [127:0] rk;
      rst  = 1'b1;
      k0_i = KEY_A;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         tests_run++;
         if (kj_o !== KEY_A[63:0] || dbg_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_hold[%0d]: kj_o=%h state=%0d, want %h state=0", i, kj_o, dbg_state, KEY_A[63:0]);
         end
      end
      rk = {$urandom, $urandom, $urandom, $urandom};
      k0_i = rk;
      #1;
      tests_run++;
      if (kj_o !== rk[63:0]) begin
         tests_failed++;
         $display("FAIL reset_passthru: kj_o=%h want %h", kj_o, rk[63:0]);
      end
   endtask

   task automatic test_full_schedule;
      logic [63:0] got, exp;
      bit          have;
      start_seq(KEY_A);
      for (int i = 0; i < 68; i++) begin
         next_sample(got, exp, have);
         seen[i] = got;
         tests_run++;
         if (!have || got !== exp) begin
            tests_failed++;
            $display("FAIL schedule k%0d: got %h want %h (queued=%0d)", i, got, exp, have);
         end
         if (i == 0) begin
            tests_run++;
            if (got !== 64'h0b0a090803020100) begin
               tests_failed++;
               $display("FAIL start_k0: got %h want 0b0a090803020100", got);
            end
         end
         if (i == 1) begin
            tests_run++;
            if (got !== 64'h1b1a191813121110) begin
               tests_failed++;
               $display("FAIL start_k1: got %h want 1b1a191813121110", got);
            end
         end
      end
      tests_run++;
      if (dbg_state !== 2'd2) begin
         tests_failed++;
         $display("FAIL done_state: got %0d want 2", dbg_state);
      end
   endtask

   task automatic test_z_wrap;
      tests_run++;
      if (seen[64] !== mk[64]) begin
         tests_failed++;
         $display("FAIL z_wrap_k64: got %h want %h", seen[64], mk[64]);
      end
      tests_run++;
      if (seen[65] !== mk[65]) begin
         tests_failed++;
         $display("FAIL z_wrap_k65: got %h want %h", seen[65], mk[65]);
      end
   endtask

   // Continues straight on from test_full_schedule: 12 more cycles make 80 in total.
   task automatic test_terminal_hold;
      logic [63:0] got, exp;
      bit          have;
      for (int i = 0; i < 12; i++) exp_q.push_back(mk[67]);
      for (int i = 0; i < 12; i++) begin
         k0_i = {$urandom, $urandom, $urandom, $urandom};
         next_sample(got, exp, have);
         tests_run++;
         if (!have || got !== exp) begin
            tests_failed++;
            $display("FAIL hold[%0d]: got %h want %h", 68 + i, got, exp);
         end
      end
   endtask

   task automatic test_async_reset;
      logic [63:0] got, exp;
      bit          have;
      start_seq(KEY_A);
      for (int i = 0; i <= 30; i++) begin
         next_sample(got, exp, have);
         tests_run++;
         if (!have || got !== exp) begin
            tests_failed++;
            $display("FAIL pre_reset k%0d: got %h want %h", i, got, exp);
         end
      end
      #1 rst = 1'b1;
      #1;
      tests_run++;
      if (kj_o !== KEY_A[63:0] || dbg_state !== 2'd0) begin
         tests_failed++;
         $display("FAIL async_reset: kj_o=%h state=%0d, want %h state=0", kj_o, dbg_state, KEY_A[63:0]);
      end
      start_seq(KEY_A);
      for (int i = 0; i < 68; i++) begin
         next_sample(got, exp, have);
         tests_run++;
         if (!have || got !== exp) begin
            tests_failed++;
            $display("FAIL restart k%0d: got %h want %h", i, got, exp);
         end
      end
   endtask

   task automatic test_key_change;
      logic [63:0] got, exp;
      bit          have;
      start_seq(128'd0);
      for (int i = 0; i < 68; i++) begin
         next_sample(got, exp, have);
         tests_run++;
         if (!have || got !== exp) begin
            tests_failed++;
            $display("FAIL zero_key k%0d: got %h want %h", i, got, exp);
         end
         if (i < 2) begin
            tests_run++;
            if (got !== 64'd0) begin
               tests_failed++;
               $display("FAIL zero_key_const k%0d: got %h want 0", i, got);
            end
         end
         if (i == 2) begin
            tests_run++;
            if (got !== 64'hFFFF_FFFF_FFFF_FFFD) begin
               tests_failed++;
               $display("FAIL zero_key_k2: got %h want fffffffffffffffd", got);
            end
         end
      end
   endtask

   // Random keys; k0_i is scrambled once the first post-reset clock has loaded it.
   task automatic test_key_ignored;
      logic [63:0] got, exp;
      bit          have;
      for (int n = 0; n < 2; n++) begin
         start_seq({$urandom, $urandom, $urandom, $urandom});
         for (int i = 0; i < 68; i++) begin
            next_sample(got, exp, have);
            if (i == 1) k0_i = {$urandom, $urandom, $urandom, $urandom};
            tests_run++;
            if (!have || got !== exp) begin
               tests_failed++;
               $display("FAIL rand_key%0d k%0d: got %h want %h", n, i, got, exp);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_schedule();
      test_z_wrap();
      test_terminal_hold();
      test_async_reset();
      test_key_change();
      test_key_ignored();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
